// File: rtl/pipeline_issue_ctrl.sv
// Issue sequencer for the 8-bit pipelined processor: host FIFO, one issue or NOP per cycle,
// and an in-flight slot pipeline that tags each returning result with its opcode and sequence number.
module pipeline_issue_ctrl #(
    parameter int         DEPTH     = 4,
    parameter int         LAT       = 3,
    parameter logic [7:0] NOP_INSTR = 8'b11_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_instr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       hold,
    input  logic       flush,
    output logic [7:0] proc_instr,
    input  logic [7:0] proc_res,
    output logic [7:0] out_res,
    output logic [1:0] out_op,
    output logic [3:0] out_tag,
    output logic       out_valid,
    output logic       busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int PTRW = PW + 1;
    localparam int CW   = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_drain_cnt, w_drain_cnt_next;
    logic [7:0]      r_fifo [DEPTH];
    logic [PTRW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_next, w_rd_ptr_next;
    logic            w_empty, w_full, w_push, w_issue, w_empty_next, w_inflight_next;
    logic [7:0]      w_head;
    logic [3:0]      r_tag;
    logic            r_cur_valid;
    logic [1:0]      r_cur_op;
    logic [3:0]      r_cur_tag;
    logic [LAT-1:0]  r_slot_valid, w_slot_valid_next;
    logic [1:0]      r_slot_op  [LAT];
    logic [3:0]      r_slot_tag [LAT];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign in_ready      = rst && !w_full && (r_state != DRAIN);
    assign w_push        = in_valid && in_ready && !flush;
    assign w_issue       = (r_state == RUN) && !hold && !flush && !w_empty;
    assign w_head        = r_fifo[r_rd_ptr[PW-1:0]];
    assign w_wr_ptr_next = r_wr_ptr + PTRW'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + PTRW'(w_issue);
    assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);

    // r_cur tracks the word on proc_instr; r_slot[k] is that word k+1 cycles later.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_slot_next
            if (gi == 0) begin : g_first
                assign w_slot_valid_next[gi] = r_cur_valid;
            end else begin : g_rest
                assign w_slot_valid_next[gi] = r_slot_valid[gi-1];
            end
        end
    endgenerate

    assign w_inflight_next = w_issue || (|w_slot_valid_next);

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        if (flush) begin
            w_state_next     = DRAIN;
            w_drain_cnt_next = CW'(LAT - 1);
        end else begin
            case (r_state)
                IDLE:    if (w_push) w_state_next = RUN;
                RUN:     if (w_empty_next && !w_inflight_next) w_state_next = IDLE;
                DRAIN: begin
                    if (r_drain_cnt == '0) w_state_next = IDLE;
                    else                   w_drain_cnt_next = r_drain_cnt - CW'(1);
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_drain_cnt  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tag        <= '0;
            proc_instr   <= NOP_INSTR;
            r_cur_valid  <= 1'b0;
            r_cur_op     <= '0;
            r_cur_tag    <= '0;
            r_slot_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_slot_op[i]  <= '0;
                r_slot_tag[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            if (flush) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_cur_valid  <= 1'b0;
                r_slot_valid <= '0;
            end else begin
                r_wr_ptr     <= w_wr_ptr_next;
                r_rd_ptr     <= w_rd_ptr_next;
                r_cur_valid  <= w_issue;
                r_slot_valid <= w_slot_valid_next;
            end
            proc_instr <= w_issue ? w_head : NOP_INSTR;
            if (w_issue) r_tag <= r_tag + 4'd1;
            r_cur_op      <= w_head[7:6];
            r_cur_tag     <= r_tag;
            r_slot_op[0]  <= r_cur_op;
            r_slot_tag[0] <= r_cur_tag;
            for (int i = 1; i < LAT; i++) begin
                r_slot_op[i]  <= r_slot_op[i-1];
                r_slot_tag[i] <= r_slot_tag[i-1];
            end
        end
    end

    assign out_valid = r_slot_valid[LAT-1];
    assign out_res   = out_valid ? proc_res : '0;
    assign out_op    = out_valid ? r_slot_op[LAT-1] : '0;
    assign out_tag   = out_valid ? r_slot_tag[LAT-1] : '0;
    assign busy      = !w_empty || r_cur_valid || (|r_slot_valid) || (r_state != IDLE);

endmodule
